fifo_drain_ctrl: RTL and testbench
==================================

Name: fifo_drain_ctrl

Overview:
- Read-side controller sitting directly downstream of the synchronous circular-buffer FIFO.
- Drives the FIFO's rd_en and clear, and absorbs the FIFO's 1-cycle registered read latency into a small skid buffer.
- Presents FIFO contents on a valid/ready stream to the next stage, at full throughput when the consumer is always ready.
- Handles flush requests, halts on FIFO error, and counts delivered packets.

Parameters:
DATA_W, 8, width of one data_packet_sp word (must equal $bits(data_packet_sp))
SKID_DEPTH, 3, skid-buffer entries; must be >= 3 for 1 word/cycle throughput; legal range 2..8
CNT_W, 16, width of the delivered-packet counter

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  asynchronous active-low reset
enable  in  1  allows new FIFO reads when high
flush  in  1  single-cycle request: discard buffered data and clear the FIFO
err_clr  in  1  releases HALT
fifo_rd_data  in  DATA_W  FIFO rd_data
fifo_empty  in  1  FIFO empty flag
fifo_error  in  1  FIFO error flag
fifo_rd_en  out  1  FIFO read request
fifo_clear  out  1  FIFO clear request
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  DATA_W  stream data
halted  out  1  high in HALT
pkt_cnt  out  CNT_W  number of words delivered (out_valid & out_ready)

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, skid buffer empty, inflight=0, pkt_cnt=0; all outputs 0.
- FIFO read timing: fifo_rd_en high with fifo_empty=0 at edge E sets inflight; fifo_rd_data is captured into the skid tail at edge E+1.
- Credit rule (combinational): fifo_rd_en = (state==RUN) & !fifo_empty & (count + inflight < SKID_DEPTH).
  - fifo_rd_en does not depend on out_ready.
  - The buffer never overflows.
- Output stream:
  - out_valid = (count != 0); out_data = head entry.
  - Head pops when out_valid & out_ready.
  - Capture and pop in the same edge leave count unchanged.
  - Entries leave in FIFO order.
  - out_data is held stable while out_valid & !out_ready.
- pkt_cnt increments on each pop and wraps 2^CNT_W-1 -> 0.
- States:
  - IDLE: fifo_rd_en=0; the stream still drains buffered and in-flight words. enable=1 -> RUN.
  - RUN: reads issued per the credit rule. enable=0 -> IDLE (in-flight word is still captured).
  - FLUSH: exactly 1 cycle; fifo_clear=1, fifo_rd_en=0. Next state is RUN if enable, else IDLE.
  - HALT: fifo_rd_en=0, halted=1; buffered words still drain. err_clr=1 -> FLUSH.
- Entering FLUSH: flush=1 sampled in IDLE or RUN. On that edge:
  - count := 0, inflight := 0;
  - any word returning from an earlier read is discarded, not captured;
  - a pop on that same edge is discarded and is not counted.
- Entering HALT: fifo_error=1 sampled in IDLE, RUN or FLUSH.
  - Priority over flush in the same cycle; the buffer is not discarded.
  - An in-flight word is still captured.
- In HALT: flush is ignored; fifo_error remaining high has no further effect. err_clr outside HALT is ignored.
- fifo_clear is high only in FLUSH.
- Reset mid-operation: immediate return to the reset values; no partial capture.
- fifo_empty=1 with credit available: no read issued and no bubble state; reads resume the cycle fifo_empty falls.

Test Plan:
- Reset then enable=1, FIFO preloaded A1..A8, out_ready=1 -> out_data A1..A8 on 8 consecutive cycles starting 2 cycles after the first fifo_rd_en; pkt_cnt=8.
- FIFO preloaded 10 words, out_ready=0 -> exactly 3 fifo_rd_en pulses, count=3, out_data=first word held; raise out_ready -> all 10 words delivered in order.
- flush pulse while count=2 and inflight=1 -> fifo_clear high for exactly 1 cycle; out_valid=0 the next cycle; in-flight word never appears; pkt_cnt unchanged.
- fifo_error=1 and flush=1 in the same cycle with 2 words buffered -> halted=1, fifo_clear stays 0, both buffered words still delivered, no further reads; err_clr=1 -> 1-cycle fifo_clear, halted=0.
- pkt_cnt preset to 0xFFFE via 65534 transfers, then 3 more -> counts 0xFFFF, 0x0000, 0x0001.
- RESET asserted asynchronously mid-stream (count=2) -> all outputs 0 immediately, without waiting for a clock edge; after release with enable=1 and FIFO empty, fifo_rd_en stays 0.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for a synchronous FIFO: issues credit-limited reads, absorbs the
// one-cycle read latency in a skid buffer and presents the data on a valid/ready stream.
`timescale 1ns/1ps

module fifo_drain_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SKID_DEPTH = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              enable,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  input  logic              fifo_error,
  output logic              fifo_rd_en,
  output logic              fifo_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);
  localparam logic [OCC_W:0]   DEPTH_L = (OCC_W + 1)'(SKID_DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(SKID_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic               halted_q, clear_q;

  logic               flush_take, halt_take, push, pop;
  logic [OCC_W:0]     occ;

  always_comb begin
    occ        = {1'b0, count_q} + {{OCC_W{1'b0}}, inflight_q};
    fifo_rd_en = (state_q == RUN) & ~fifo_empty & (occ < DEPTH_L);
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign halted     = halted_q;
  assign fifo_clear = clear_q;
  assign pkt_cnt    = pkt_cnt_q;

  always_comb begin
    // An error in the same cycle wins over a flush, so the buffer survives into HALT.
    halt_take  = fifo_error & (state_q != HALT);
    flush_take = flush & ~fifo_error & ((state_q == IDLE) | (state_q == RUN));
    push       = inflight_q & ~flush_take;
    pop        = out_valid & out_ready & ~flush_take;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (halt_take)       state_d = HALT;
        else if (flush_take) state_d = FLUSH;
        else if (enable)     state_d = RUN;
      end
      RUN: begin
        if (halt_take)       state_d = HALT;
        else if (flush_take) state_d = FLUSH;
        else if (!enable)    state_d = IDLE;
      end
      FLUSH: begin
        if (halt_take)       state_d = HALT;
        else if (enable)     state_d = RUN;
        else                 state_d = IDLE;
      end
      HALT: begin
        if (err_clr)         state_d = FLUSH;
      end
      default:               state_d = IDLE;
    endcase

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_take) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end

    inflight_d = fifo_rd_en & ~flush_take;
    pkt_cnt_d  = pop ? pkt_cnt_q + CNT_W'(1) : pkt_cnt_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      pkt_cnt_q  <= '0;
      halted_q   <= 1'b0;
      clear_q    <= 1'b0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      pkt_cnt_q  <= pkt_cnt_d;
      halted_q   <= (state_d == HALT);
      clear_q    <= (state_d == FLUSH);
      if (push) mem_q[wr_ptr_q] <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: a cycle table with hand-computed outputs,
// then sequences against a small behavioural FIFO for streaming, flush, reset and wrap cases.
`timescale 1ns/1ps

module tb_fifo_drain_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       enable = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [7:0] fifo_rd_data = '0;
  logic       fifo_empty = 1'b1, fifo_error = 1'b0;
  logic       fifo_rd_en, fifo_clear, out_valid, halted;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int failures = 0;

  logic       use_model = 1'b0;
  logic [7:0] fq [$];

  fifo_drain_ctrl #(.DATA_W(8), .SKID_DEPTH(3), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .flush(flush), .err_clr(err_clr),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_error(fifo_error),
    .fifo_rd_en(fifo_rd_en), .fifo_clear(fifo_clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .halted(halted), .pkt_cnt(pkt_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       en, fl, ec, emp, err, rdy;
    logic [7:0] rdat;
    logic       e_rden, e_clr, e_val;
    logic [7:0] e_data;
    logic       e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Decide the FIFO model's reaction from settled inputs, then advance past the edge.
  task automatic tick();
    logic do_pop, do_clr;
    do_clr = use_model && fifo_clear;
    do_pop = use_model && fifo_rd_en && !fifo_empty;
    @(posedge CLK);
    #1;
    if (do_clr) fq.delete();
    else if (do_pop) fifo_rd_data = fq.pop_front();
    if (use_model) fifo_empty = (fq.size() == 0);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    enable = 1'b0; flush = 1'b0; err_clr = 1'b0; fifo_error = 1'b0; out_ready = 1'b0;
    use_model = 1'b0; fifo_empty = 1'b1; fq.delete();
    tick();
    tick();
    RESET = 1'b1;
  endtask

  task automatic preload(input int n, input logic [7:0] base);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    use_model = 1'b1;
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    //        en fl ec emp err rdy rdat  | rden clr val data halt cnt
    vecs[0]  = '{0,0,0,1,0,0,8'h00, 0,0,0,8'h00,0,16'd0};
    vecs[1]  = '{1,0,0,0,0,0,8'h00, 0,0,0,8'h00,0,16'd0};
    vecs[2]  = '{1,0,0,0,0,0,8'h00, 1,0,0,8'h00,0,16'd0};
    vecs[3]  = '{1,0,0,0,0,0,8'h11, 1,0,0,8'h00,0,16'd0};
    vecs[4]  = '{1,0,0,0,0,0,8'h22, 1,0,1,8'h11,0,16'd0};
    vecs[5]  = '{1,0,0,0,0,0,8'h33, 0,0,1,8'h11,0,16'd0};
    vecs[6]  = '{1,0,0,0,0,0,8'h99, 0,0,1,8'h11,0,16'd0};
    vecs[7]  = '{1,0,0,0,0,1,8'h99, 0,0,1,8'h11,0,16'd0};
    vecs[8]  = '{1,0,0,0,0,1,8'h99, 1,0,1,8'h22,0,16'd1};
    vecs[9]  = '{1,0,0,0,0,1,8'h44, 1,0,1,8'h33,0,16'd2};
    vecs[10] = '{1,1,0,0,0,0,8'h55, 1,0,1,8'h44,0,16'd3};
    vecs[11] = '{1,0,0,0,0,0,8'h66, 0,1,0,8'h00,0,16'd3};
    vecs[12] = '{1,0,0,1,0,0,8'h66, 0,0,0,8'h00,0,16'd3};
    vecs[13] = '{1,1,0,0,1,0,8'h66, 1,0,0,8'h00,0,16'd3};
    vecs[14] = '{1,0,0,0,0,0,8'h77, 0,0,0,8'h00,1,16'd3};
    vecs[15] = '{1,1,0,0,0,0,8'h88, 0,0,1,8'h77,1,16'd3};
    vecs[16] = '{1,0,0,0,0,1,8'h88, 0,0,1,8'h77,1,16'd3};
    vecs[17] = '{1,0,1,0,0,1,8'h88, 0,0,0,8'h00,1,16'd4};
    vecs[18] = '{0,0,0,0,0,0,8'h88, 0,1,0,8'h00,0,16'd4};
    vecs[19] = '{0,0,1,0,0,0,8'h88, 0,0,0,8'h00,0,16'd4};
    vecs[20] = '{0,0,0,0,0,0,8'h88, 0,0,0,8'h00,0,16'd4};

    // Asynchronous reset from time zero
    #1 RESET = 1'b0;
    #2;
    chk("rst_rden",  {31'd0, fifo_rd_en}, 0);
    chk("rst_clear", {31'd0, fifo_clear}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data",  {24'd0, out_data}, 0);
    chk("rst_halt",  {31'd0, halted}, 0);
    chk("rst_cnt",   {16'd0, pkt_cnt}, 0);
    do_reset();

    // Cycle table: reads, credit stall, flush, error+flush priority, HALT drain, err_clr
    for (int i = 0; i < 21; i++) begin
      enable = vecs[i].en; flush = vecs[i].fl; err_clr = vecs[i].ec;
      fifo_empty = vecs[i].emp; fifo_error = vecs[i].err; out_ready = vecs[i].rdy;
      fifo_rd_data = vecs[i].rdat;
      #2;
      chk($sformatf("v%0d_rden", i),  {31'd0, fifo_rd_en}, {31'd0, vecs[i].e_rden});
      chk($sformatf("v%0d_clear", i), {31'd0, fifo_clear}, {31'd0, vecs[i].e_clr});
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid},  {31'd0, vecs[i].e_val});
      if (vecs[i].e_val) chk($sformatf("v%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_data});
      chk($sformatf("v%0d_halt", i),  {31'd0, halted},     {31'd0, vecs[i].e_halt});
      chk($sformatf("v%0d_cnt", i),   {16'd0, pkt_cnt},    {16'd0, vecs[i].e_cnt});
      tick();
    end

    // Full-throughput stream of A1..A8
    begin
      logic rd [25];
      logic vl [25];
      logic [7:0] dt [25];
      int first;
      do_reset();
      preload(8, 8'hA1);
      enable = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 25; c++) begin
        #2;
        rd[c] = fifo_rd_en; vl[c] = out_valid; dt[c] = out_data;
        tick();
      end
      first = -1;
      for (int c = 24; c >= 0; c--) if (rd[c]) first = c;
      chk("strm_first_rd", first, 1);
      if (first >= 0 && first + 10 < 25) begin
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("strm_val%0d", k), {31'd0, vl[first+2+k]}, 1);
          chk($sformatf("strm_dat%0d", k), {24'd0, dt[first+2+k]}, {24'd0, 8'hA1 + 8'(k)});
        end
        chk("strm_val_end", {31'd0, vl[first+10]}, 0);
      end
      chk("strm_cnt", {16'd0, pkt_cnt}, 8);
    end

    // Consumer stalled: only SKID_DEPTH reads, head held; then drain in order
    begin
      int npulse, got;
      do_reset();
      preload(10, 8'h30);
      enable = 1'b1; out_ready = 1'b0;
      npulse = 0;
      for (int c = 0; c < 12; c++) begin
        #2;
        if (fifo_rd_en) npulse++;
        tick();
      end
      chk("stall_reads", npulse, 3);
      #2;
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_head",  {24'd0, out_data}, 8'h30);
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30; c++) begin
        #2;
        if (out_valid) begin
          chk($sformatf("drain_dat%0d", got), {24'd0, out_data}, {24'd0, 8'h30 + 8'(got)});
          got++;
        end
        tick();
      end
      chk("drain_words", got, 10);
      chk("drain_cnt", {16'd0, pkt_cnt}, 10);
    end

    // Reset asserted between edges with two words buffered
    begin
      do_reset();
      preload(6, 8'hC0);
      enable = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      #2;
      chk("mid_valid_pre", {31'd0, out_valid}, 1);
      chk("mid_data_pre",  {24'd0, out_data}, 8'hC0);
      RESET = 1'b0;
      #1;
      chk("mid_valid", {31'd0, out_valid}, 0);
      chk("mid_data",  {24'd0, out_data}, 0);
      chk("mid_rden",  {31'd0, fifo_rd_en}, 0);
      chk("mid_halt",  {31'd0, halted}, 0);
      chk("mid_clear", {31'd0, fifo_clear}, 0);
      use_model = 1'b0; fq.delete(); fifo_empty = 1'b1;
      tick();
      RESET = 1'b1;
      for (int c = 0; c < 5; c++) begin
        #2;
        chk($sformatf("empty_rden%0d", c), {31'd0, fifo_rd_en}, 0);
        tick();
      end
      fifo_empty = 1'b0;
      #2;
      chk("resume_rden", {31'd0, fifo_rd_en}, 1);
      tick();
    end

    // Packet counter wrap
    begin
      logic hit;
      do_reset();
      fifo_empty = 1'b0; fifo_rd_data = 8'h5A;
      enable = 1'b1; out_ready = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 70000; c++) begin
        #2;
        if (pkt_cnt == 16'hFFFE) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      chk("wrap_reach", {31'd0, hit}, 1);
      out_ready = 1'b0;
      tick(); tick(); tick();
      fifo_empty = 1'b1;
      for (int k = 0; k < 3; k++) begin
        out_ready = 1'b1;
        #2;
        chk($sformatf("wrap_val%0d", k), {31'd0, out_valid}, 1);
        tick();
        out_ready = 1'b0;
        #2;
        chk($sformatf("wrap_cnt%0d", k), {16'd0, pkt_cnt}, {16'd0, 16'hFFFF + 16'(k)});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
